// File: rtl/idma_noc_pkt_framer.sv
// -----------------------------------------------------------------------------
// idma_noc_pkt_framer
// Turns the raw DMA flit stream into NoC packets for the router local port.
// Each packet starts with one head flit {cont, seq, src, dst}. Bursts longer
// than MAX_PKT_FLITS body flits are split into chained packets; the follow-on
// heads carry cont=1. Sending is gated by a credit counter that mirrors the
// free slots of the router input buffer.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   cfg_dst_id/src_id    node ids, sampled when a head flit is emitted
//   s_valid/s_flit/
//   s_last/s_ready       DMA side stream (valid/ready handshake)
//   noc_valid/noc_flit/
//   noc_head/noc_last    registered flit toward the router
//   noc_credit           one-cycle pulse, router freed one buffer slot
//   pkt_cnt              packets sent since reset (wraps)
//   err_credit_ovf       sticky: credit returned while counter was full
// -----------------------------------------------------------------------------
module idma_noc_pkt_framer #(
   parameter int FLIT_WID      = 256,
   parameter int NODE_ID_WID   = 4,
   parameter int CREDIT_NUM    = 4,
   parameter int CREDIT_WID    = 3,
   parameter int MAX_PKT_FLITS = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [NODE_ID_WID-1:0] cfg_dst_id,
   input  logic [NODE_ID_WID-1:0] cfg_src_id,
   input  logic                   s_valid,
   input  logic [FLIT_WID-1:0]    s_flit,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic                   noc_valid,
   output logic [FLIT_WID-1:0]    noc_flit,
   output logic                   noc_head,
   output logic                   noc_last,
   input  logic                   noc_credit,
   output logic [15:0]            pkt_cnt,
   output logic                   err_credit_ovf
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BODY = 1'b1;

   localparam int BCNT_WID = $clog2(MAX_PKT_FLITS);
   localparam logic [CREDIT_WID-1:0] CREDIT_INIT = CREDIT_WID'(CREDIT_NUM);
   localparam logic [BCNT_WID-1:0]   BODY_MAX    = BCNT_WID'(MAX_PKT_FLITS - 1);

   logic [0:0]            state;
   logic [CREDIT_WID-1:0] credit;
   logic [15:0]           seq;
   logic [BCNT_WID-1:0]   body_cnt;
   logic                  cont;

   logic                  can_send;
   logic                  send_head;
   logic                  send_body;
   logic                  send;
   logic                  pkt_end;
   logic [FLIT_WID-1:0]   head_flit;

   assign can_send  = (credit != '0);
   assign s_ready   = (state == ST_BODY) && can_send;
   assign send_head = (state == ST_IDLE) && s_valid && can_send;
   assign send_body = (state == ST_BODY) && s_valid && can_send;
   assign send      = send_head || send_body;

   // A packet closes either on the burst's own last flit or when the body
   // limit is hit; in the latter case the burst resumes behind a cont head.
   assign pkt_end   = send_body && (s_last || (body_cnt == BODY_MAX));

   // Head flit assembled from the live cfg inputs, so it reflects the ids
   // present in the cycle the head is emitted.
   always_comb begin
      head_flit = '0;
      head_flit[NODE_ID_WID-1:0]                 = cfg_dst_id;
      head_flit[2*NODE_ID_WID-1:NODE_ID_WID]     = cfg_src_id;
      head_flit[2*NODE_ID_WID+15:2*NODE_ID_WID]  = seq;
      head_flit[2*NODE_ID_WID+16]                = cont;
   end

   // Framing FSM and output register. Output flit/head/last only load on a
   // send; noc_valid is a one-cycle pulse per emitted flit.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= ST_IDLE;
         seq       <= '0;
         body_cnt  <= '0;
         cont      <= 1'b0;
         pkt_cnt   <= '0;
         noc_valid <= 1'b0;
         noc_flit  <= '0;
         noc_head  <= 1'b0;
         noc_last  <= 1'b0;
      end else begin
         noc_valid <= send;
         if (send_head) begin
            noc_flit <= head_flit;
            noc_head <= 1'b1;
            noc_last <= 1'b0;
            body_cnt <= '0;
            state    <= ST_BODY;
         end else if (send_body) begin
            noc_flit <= s_flit;
            noc_head <= 1'b0;
            noc_last <= pkt_end;
            body_cnt <= body_cnt + 1'b1;
            if (pkt_end) begin
               seq     <= seq + 16'd1;
               pkt_cnt <= pkt_cnt + 16'd1;
               cont    <= ~s_last;
               state   <= ST_IDLE;
            end
         end
      end
   end

   // Credit counter. A send and a return in the same cycle cancel out; a
   // return with the counter already full is a protocol error from the
   // router and is latched until reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         credit         <= CREDIT_INIT;
         err_credit_ovf <= 1'b0;
      end else begin
         if (send && !noc_credit) begin
            credit <= credit - CREDIT_WID'(1);
         end else if (noc_credit && !send) begin
            if (credit == CREDIT_INIT) begin
               err_credit_ovf <= 1'b1;
            end else begin
               credit <= credit + CREDIT_WID'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_idma_noc_pkt_framer.sv
// -----------------------------------------------------------------------------
// tb_idma_noc_pkt_framer
// Directed testbench for idma_noc_pkt_framer. A negedge monitor records every
// emitted flit; the stimulus block drives bursts, credit pulses and resets and
// compares the recorded flits against hand-computed packets.
// -----------------------------------------------------------------------------
module tb_idma_noc_pkt_framer;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [3:0]   cfg_dst_id;
   logic [3:0]   cfg_src_id;
   logic         s_valid;
   logic [255:0] s_flit;
   logic         s_last;
   logic         s_ready;
   logic         noc_valid;
   logic [255:0] noc_flit;
   logic         noc_head;
   logic         noc_last;
   logic         noc_credit;
   logic [15:0]  pkt_cnt;
   logic         err_credit_ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   // burst source state
   int       len;
   int       idx;
   logic [7:0] tag;
   logic     auto_credit;
   logic     credit_pulse;
   int       mark;

   // flits observed on the NoC side
   logic [255:0] mon_flit[$];
   logic         mon_head[$];
   logic         mon_last[$];

   idma_noc_pkt_framer dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .cfg_dst_id     (cfg_dst_id),
      .cfg_src_id     (cfg_src_id),
      .s_valid        (s_valid),
      .s_flit         (s_flit),
      .s_last         (s_last),
      .s_ready        (s_ready),
      .noc_valid      (noc_valid),
      .noc_flit       (noc_flit),
      .noc_head       (noc_head),
      .noc_last       (noc_last),
      .noc_credit     (noc_credit),
      .pkt_cnt        (pkt_cnt),
      .err_credit_ovf (err_credit_ovf)
   );

   always #5 aclk = ~aclk;

   // capture each emitted flit away from the active edge
   always @(negedge aclk) begin
      if (noc_valid === 1'b1) begin
         mon_flit.push_back(noc_flit);
         mon_head.push_back(noc_head);
         mon_last.push_back(noc_last);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [255:0] flit_of(input logic [7:0] t, input int i);
      logic [255:0] f;
      f = '0;
      f[255:248] = t;
      f[7:0]     = 8'(i);
      f[131:124] = ~8'(i);
      return f;
   endfunction

   function automatic logic [255:0] exp_head(input logic [3:0] d, input logic [3:0] s,
                                             input logic [15:0] q, input logic c);
      logic [255:0] h;
      h = '0;
      h[3:0]  = d;
      h[7:4]  = s;
      h[23:8] = q;
      h[24]   = c;
      return h;
   endfunction

   task automatic check_output(input string name, input logic [255:0] obs, input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   // compare the recorded flit at position pos (relative to mark)
   task automatic check_flit(input string name, input int pos, input logic [255:0] f,
                             input logic h, input logic l);
      check_output({name, ".flit"}, mon_flit[mark+pos], f);
      check_output({name, ".head"}, 256'(mon_head[mark+pos]), 256'(h));
      check_output({name, ".last"}, 256'(mon_last[mark+pos]), 256'(l));
   endtask

   // one negedge-aligned cycle per iteration: drive source and credit inputs
   task automatic apply_stimulus(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge aclk);
         noc_credit   = (auto_credit && (noc_valid === 1'b1)) || credit_pulse;
         credit_pulse = 1'b0;
         if (idx < len) begin
            s_valid = 1'b1;
            s_flit  = flit_of(tag, idx);
            s_last  = (idx == len - 1);
         end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         #1;
         if (s_valid && (s_ready === 1'b1)) idx++;
      end
   endtask

   task automatic run_burst(input string name, input int budget);
      int c;
      c = 0;
      while (idx < len && c < budget) begin
         apply_stimulus(1);
         c++;
      end
      check_output({name, ".accepted"}, 256'(idx), 256'(len));
      apply_stimulus(4);
   endtask

   task automatic start_burst(input int l, input logic [7:0] t, input logic a);
      len         = l;
      tag         = t;
      idx         = 0;
      auto_credit = a;
      mark        = mon_flit.size();
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn    = 1'b0;
      s_valid    = 1'b0;
      s_last     = 1'b0;
      noc_credit = 1'b0;
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      len     = 0;
      idx     = 0;
   endtask

   initial begin
      aresetn      = 1'b0;
      cfg_dst_id   = 4'd5;
      cfg_src_id   = 4'd2;
      s_valid      = 1'b0;
      s_flit       = '0;
      s_last       = 1'b0;
      noc_credit   = 1'b0;
      auto_credit  = 1'b0;
      credit_pulse = 1'b0;
      len          = 0;
      idx          = 0;
      tag          = 8'h00;
      mark         = 0;

      // reset state
      do_reset();
      #1;
      check_output("rst.noc_valid", 256'(noc_valid), 256'(0));
      check_output("rst.noc_flit", noc_flit, 256'(0));
      check_output("rst.noc_head", 256'(noc_head), 256'(0));
      check_output("rst.noc_last", 256'(noc_last), 256'(0));
      check_output("rst.pkt_cnt", 256'(pkt_cnt), 256'(0));
      check_output("rst.err", 256'(err_credit_ovf), 256'(0));
      check_output("rst.s_ready", 256'(s_ready), 256'(0));

      // test 1: 3-flit burst, ample credits
      $display("[TB] test 1: short burst");
      start_burst(3, 8'h11, 1'b1);
      run_burst("t1", 40);
      check_output("t1.count", 256'(mon_flit.size() - mark), 256'(4));
      check_flit("t1.hd", 0, exp_head(4'd5, 4'd2, 16'd0, 1'b0), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         check_flit($sformatf("t1.b%0d", i), 1 + i, flit_of(8'h11, i), 1'b0, (i == 2));
      check_output("t1.pkt_cnt", 256'(pkt_cnt), 256'(1));

      // test 2: 20-flit burst split into 16 + 4; dst changed mid packet A
      $display("[TB] test 2: split burst");
      do_reset();
      start_burst(20, 8'h22, 1'b1);
      for (int c = 0; c < 40 && idx < 8; c++) apply_stimulus(1);
      cfg_dst_id = 4'd7;
      run_burst("t2", 80);
      check_output("t2.count", 256'(mon_flit.size() - mark), 256'(22));
      check_flit("t2.hdA", 0, exp_head(4'd5, 4'd2, 16'd0, 1'b0), 1'b1, 1'b0);
      for (int i = 0; i < 16; i++)
         check_flit($sformatf("t2.a%0d", i), 1 + i, flit_of(8'h22, i), 1'b0, (i == 15));
      check_flit("t2.hdB", 17, exp_head(4'd7, 4'd2, 16'd1, 1'b1), 1'b1, 1'b0);
      for (int i = 16; i < 20; i++)
         check_flit($sformatf("t2.b%0d", i), 2 + i, flit_of(8'h22, i), 1'b0, (i == 19));
      check_output("t2.pkt_cnt", 256'(pkt_cnt), 256'(2));
      cfg_dst_id = 4'd5;

      // test 6 (run here so seq/pkt_cnt are non-zero): reset mid packet
      $display("[TB] test 6: reset mid packet");
      start_burst(8, 8'h66, 1'b1);
      for (int c = 0; c < 40 && (mon_flit.size() - mark) < 3; c++) apply_stimulus(1);
      aresetn    = 1'b0;
      s_valid    = 1'b0;
      s_last     = 1'b0;
      noc_credit = 1'b0;
      @(negedge aclk);
      #1;
      check_output("t6.count", 256'(mon_flit.size() - mark), 256'(3));
      check_flit("t6.hd", 0, exp_head(4'd5, 4'd2, 16'd2, 1'b0), 1'b1, 1'b0);
      check_flit("t6.b1", 2, flit_of(8'h66, 1), 1'b0, 1'b0);
      check_output("t6.rst.noc_valid", 256'(noc_valid), 256'(0));
      check_output("t6.rst.noc_flit", noc_flit, 256'(0));
      check_output("t6.rst.noc_head", 256'(noc_head), 256'(0));
      check_output("t6.rst.pkt_cnt", 256'(pkt_cnt), 256'(0));
      check_output("t6.rst.s_ready", 256'(s_ready), 256'(0));
      aresetn = 1'b1;
      start_burst(2, 8'h67, 1'b1);
      run_burst("t6n", 40);
      check_output("t6n.count", 256'(mon_flit.size() - mark), 256'(3));
      check_flit("t6n.hd", 0, exp_head(4'd5, 4'd2, 16'd0, 1'b0), 1'b1, 1'b0);
      check_flit("t6n.b1", 2, flit_of(8'h67, 1), 1'b0, 1'b1);
      check_output("t6n.pkt_cnt", 256'(pkt_cnt), 256'(1));

      // test 3: no credit returns, 8-flit burst stalls after head + 3
      $display("[TB] test 3: credit exhaustion");
      do_reset();
      start_burst(8, 8'h33, 1'b0);
      apply_stimulus(10);
      check_output("t3.count", 256'(mon_flit.size() - mark), 256'(4));
      check_output("t3.s_ready", 256'(s_ready), 256'(0));
      check_output("t3.idx", 256'(idx), 256'(3));
      check_flit("t3.hd", 0, exp_head(4'd5, 4'd2, 16'd0, 1'b0), 1'b1, 1'b0);
      credit_pulse = 1'b1;
      apply_stimulus(5);
      check_output("t3.count1", 256'(mon_flit.size() - mark), 256'(5));
      check_flit("t3.b3", 4, flit_of(8'h33, 3), 1'b0, 1'b0);

      // test 4: credit return coinciding with a send at credit=1
      $display("[TB] test 4: simultaneous credit and send");
      credit_pulse = 1'b1;
      apply_stimulus(1);
      credit_pulse = 1'b1;
      apply_stimulus(1);
      apply_stimulus(1);
      check_output("t4.s_ready", 256'(s_ready), 256'(1));
      apply_stimulus(3);
      check_output("t4.count", 256'(mon_flit.size() - mark), 256'(7));
      check_flit("t4.b4", 5, flit_of(8'h33, 4), 1'b0, 1'b0);
      check_flit("t4.b5", 6, flit_of(8'h33, 5), 1'b0, 1'b0);
      check_output("t4.s_ready_end", 256'(s_ready), 256'(0));

      // test 5: credit return while full sets the sticky error
      $display("[TB] test 5: credit overflow");
      do_reset();
      start_burst(0, 8'h55, 1'b0);
      apply_stimulus(1);
      check_output("t5.err_before", 256'(err_credit_ovf), 256'(0));
      credit_pulse = 1'b1;
      apply_stimulus(4);
      check_output("t5.err_set", 256'(err_credit_ovf), 256'(1));
      start_burst(8, 8'h55, 1'b0);
      apply_stimulus(12);
      check_output("t5.count", 256'(mon_flit.size() - mark), 256'(4));
      check_output("t5.err_sticky", 256'(err_credit_ovf), 256'(1));
      check_output("t5.s_ready", 256'(s_ready), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
